// File: rtl/sonata_switch_debounce.sv
// Switch conditioning for the Sonata board: synchronise active-low pins, invert to on=1,
// and accept a level change only after DebounceCycles consecutive disagreeing samples.
module sonata_switch_debounce #(
  parameter int Width          = 13,
  parameter int SyncStages     = 2,
  parameter int DebounceCycles = 500000
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_ni,
  input  logic [Width-1:0] sw_raw_ni,
  output logic [Width-1:0] sw_o,
  output logic [Width-1:0] sw_rise_o,
  output logic [Width-1:0] sw_fall_o
);

  localparam int CntWidth = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(DebounceCycles - 1);

  logic [SyncStages-1:0][Width-1:0] r_sync;
  logic [Width-1:0]                 w_pressed;
  logic [Width-1:0][CntWidth-1:0]   r_cnt;
  logic [Width-1:0]                 r_sw;
  logic [Width-1:0]                 r_rise;
  logic [Width-1:0]                 r_fall;

  // Synchroniser resets to all-ones so a reset looks like every switch released.
  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_ni) begin
      r_sync <= '1;
    end else begin
      r_sync[0] <= sw_raw_ni;
      for (int k = 1; k < SyncStages; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign w_pressed = ~r_sync[SyncStages-1];

  // A sample that agrees with the current level restarts qualification, so only an
  // unbroken run of DebounceCycles disagreeing samples can flip the output.
  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_ni) begin
      r_cnt  <= '0;
      r_sw   <= '0;
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      for (int i = 0; i < Width; i++) begin
        r_rise[i] <= 1'b0;
        r_fall[i] <= 1'b0;
        if (w_pressed[i] == r_sw[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CntLast) begin
          r_sw[i]   <= w_pressed[i];
          r_cnt[i]  <= '0;
          r_rise[i] <= w_pressed[i];
          r_fall[i] <= ~w_pressed[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign sw_o      = r_sw;
  assign sw_rise_o = r_rise;
  assign sw_fall_o = r_fall;

endmodule

// File: tb/tb_sonata_switch_debounce.sv
// Bench for sonata_switch_debounce (Width=4, SyncStages=2, DebounceCycles=4): directed
// scenarios plus random hold patterns, checked cycle by cycle against a sliding-window model.
module tb_sonata_switch_debounce;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int DC = 4;

  // ---------------- clock / reset ----------------
  logic clk_sys_i = 1'b0;
  always #5 clk_sys_i = ~clk_sys_i;

  logic         rst_sys_ni = 1'b0;
  logic [W-1:0] sw_raw_ni  = '1;
  logic [W-1:0] sw_o;
  logic [W-1:0] sw_rise_o;
  logic [W-1:0] sw_fall_o;

  sonata_switch_debounce #(
    .Width         (W),
    .SyncStages    (SS),
    .DebounceCycles(DC)
  ) dut (
    .clk_sys_i (clk_sys_i),
    .rst_sys_ni(rst_sys_ni),
    .sw_raw_ni (sw_raw_ni),
    .sw_o      (sw_o),
    .sw_rise_o (sw_rise_o),
    .sw_fall_o (sw_fall_o)
  );

  // ---------------- scoreboard state ----------------
  logic [3*W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int edge_no = 0;
  int rise_cnt[W];
  int fall_cnt[W];
  int rise_at[W];
  logic [W-1:0] last_rise_vec = '0;

  // Model: pin level delayed through SS stages, then the last DC pressed samples
  // must all disagree with the held level before it flips.
  logic [W-1:0] m_d[SS];
  logic [W-1:0] m_hist[DC];
  logic [W-1:0] m_o = '0;
  logic [W-1:0] m_r = '0;
  logic [W-1:0] m_f = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [W-1:0] s;
    logic         all_mis;
    if (!rst_sys_ni) begin
      for (int k = 0; k < SS; k++) m_d[k] = '1;
      for (int k = 0; k < DC; k++) m_hist[k] = '0;
      m_o = '0;
      m_r = '0;
      m_f = '0;
    end else begin
      s = ~m_d[SS-1];
      for (int k = DC-1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = s;
      m_r = '0;
      m_f = '0;
      for (int b = 0; b < W; b++) begin
        all_mis = 1'b1;
        for (int k = 0; k < DC; k++) if (m_hist[k][b] == m_o[b]) all_mis = 1'b0;
        if (all_mis) begin
          m_o[b] = s[b];
          m_r[b] = s[b];
          m_f[b] = ~s[b];
        end
      end
      for (int k = SS-1; k > 0; k--) m_d[k] = m_d[k-1];
      m_d[0] = sw_raw_ni;
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [W-1:0] raw, input logic rstn);
    @(negedge clk_sys_i);
    sw_raw_ni  = raw;
    rst_sys_ni = rstn;
    @(posedge clk_sys_i);
    model_edge();
    exp_q.push_back({m_o, m_r, m_f});
    edge_no++;
  endtask

  task automatic hold(input logic [W-1:0] raw, input int n);
    for (int i = 0; i < n; i++) step(raw, 1'b1);
  endtask

  task automatic clear_marks();
    for (int b = 0; b < W; b++) begin
      rise_cnt[b] = 0;
      fall_cnt[b] = 0;
      rise_at[b]  = -1;
    end
    last_rise_vec = '0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk_sys_i) begin
    if (exp_q.size() > 0) begin
      check("sb_out", {20'h0, sw_o, sw_rise_o, sw_fall_o}, {20'h0, exp_q.pop_front()});
      if (sw_rise_o != '0) last_rise_vec = sw_rise_o;
      for (int b = 0; b < W; b++) begin
        if (sw_rise_o[b]) begin
          rise_cnt[b]++;
          rise_at[b] = edge_no - 1;
        end
        if (sw_fall_o[b]) fall_cnt[b]++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int e0;
    int tot;
    logic [W-1:0] rv;
    logic [W-1:0] tv;

    clear_marks();
    // 1: reset then idle pins
    for (int i = 0; i < 3; i++) step('1, 1'b0);
    check("reset_sw", {28'h0, sw_o}, 32'h0);
    hold('1, 20);
    tot = 0;
    for (int b = 0; b < W; b++) tot += rise_cnt[b] + fall_cnt[b];
    check("idle_no_pulse", tot, 0);
    check("idle_sw", {28'h0, sw_o}, 32'h0);

    // 2: press bit0, rise latency SS+DC-1
    clear_marks();
    e0 = edge_no;
    hold(4'b1110, 10);
    check("rise0_latency", rise_at[0] - e0, SS + DC - 1);
    check("rise0_count", rise_cnt[0], 1);
    check("press0_sw", {28'h0, sw_o}, 32'h1);

    // 3: 3-cycle release glitch is rejected, long release falls once
    clear_marks();
    hold(4'b1111, 3);
    hold(4'b1110, 8);
    check("glitch_no_fall", fall_cnt[0], 0);
    check("glitch_sw", {28'h0, sw_o}, 32'h1);
    hold(4'b1111, 8);
    check("release0_fall", fall_cnt[0], 1);
    check("release0_sw", {28'h0, sw_o}, 32'h0);

    // 4: bits 1 and 3 together
    clear_marks();
    hold(4'b0101, 9);
    check("dual_rise_vec", {28'h0, last_rise_vec}, 32'ha);
    check("dual_sw", {28'h0, sw_o}, 32'ha);
    hold(4'b1111, 9);

    // 5: reset mid-qualification with bit2 held
    clear_marks();
    hold(4'b1011, 3);
    step(4'b1011, 1'b0);
    #1 check("rst_mid_sw", {28'h0, sw_o}, 32'h0);
    check("rst_mid_pulse", {28'h0, sw_rise_o | sw_fall_o}, 32'h0);
    step(4'b1011, 1'b0);
    check("rst_no_rise", rise_cnt[2], 0);
    e0 = edge_no;
    hold(4'b1011, 10);
    check("rst_rise_latency", rise_at[2] - e0, SS + DC - 1);
    check("rst_rise_count", rise_cnt[2], 1);
    hold(4'b1111, 9);

    // 6: bit0 toggling every 2 cycles never qualifies
    clear_marks();
    for (int i = 0; i < 50; i++) step((i / 2) % 2 == 0 ? 4'b1110 : 4'b1111, 1'b1);
    check("toggle_no_rise", rise_cnt[0], 0);
    check("toggle_no_fall", fall_cnt[0], 0);
    check("toggle_sw0", {31'h0, sw_o[0]}, 32'h0);

    // random hold lengths around the debounce threshold
    for (int n = 0; n < 60; n++) begin
      rv = W'($urandom_range(0, 15));
      tv = W'($urandom_range(1, 7));
      hold(rv, int'(tv));
    end
    hold('1, 10);

    @(negedge clk_sys_i);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
